// File: rtl/seq_mul_su_pkg.sv
// Shared definitions for the sequential signed x (un)signed multiplier.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
//
// Contents: FSM state enum, digit width, digit-count helper and the
// operand-width legality check used at elaboration by the top level.

package seq_mul_su_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // The multiplier consumes one digit of this many bits per BUSY cycle.
    localparam int DIGIT_W = 4;

    // Number of digits (and BUSY cycles) for a second operand of width_u bits.
    function automatic int num_digits(input int width_u);
        return width_u / DIGIT_W;
    endfunction

    // Operand widths must be whole, non-zero numbers of digits.
    function automatic bit width_ok(input int w);
        return (w >= DIGIT_W) && ((w % DIGIT_W) == 0);
    endfunction

endpackage

// File: rtl/su_digit_row.sv
// One partial-product row: signed s times a 5-bit signed digit, combinational.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   s     [WIDTH_S-1:0]  signed operand, two's complement
//   digit [4:0]          signed digit; bit 4 is the sign (-16 weight)
//   pp    [WIDTH_S+4:0]  signed product s * digit, two's complement
//
// The low 4 digit bits are multiplied against each 4-bit slice of s with a
// 4x4 tile. Only the top slice of s carries sign, so only its tile is a
// signed x unsigned tile; the lower slices are plain unsigned tiles. The
// digit's sign bit weighs -16, handled by subtracting s << 4 afterwards.

module su_digit_row #(
    parameter int WIDTH_S = 8
) (
    input  logic [WIDTH_S-1:0] s,
    input  logic [4:0]         digit,
    output logic [WIDTH_S+4:0] pp
);

    localparam int NS = WIDTH_S / 4;
    localparam int PW = WIDTH_S + 5;

    logic [3:0]    nib;
    logic [7:0]    tile;
    logic [PW-1:0] tile_ext;
    logic [PW-1:0] sum;

    always_comb begin
        sum      = '0;
        nib      = '0;
        tile     = '0;
        tile_ext = '0;
        for (int i = 0; i < NS; i++) begin
            nib = s[4*i +: 4];
            if (i == NS - 1) begin
                // Signed slice x unsigned digit: range -120..105, fits 8 bits.
                tile     = {{4{nib[3]}}, nib} * {4'b0000, digit[3:0]};
                tile_ext = PW'($signed(tile));
            end else begin
                tile     = {4'b0000, nib} * {4'b0000, digit[3:0]};
                tile_ext = PW'(tile);
            end
            sum = sum + (tile_ext << (4 * i));
        end
        // Sign-digit correction: bit 4 of the digit is worth -16.
        if (digit[4]) begin
            sum = sum - (PW'($signed(s)) << 4);
        end
        pp = sum;
    end

endmodule

// File: rtl/seq_mul_su.sv
// Sequential s * u multiplier, one 4-bit digit of u per cycle; u signed or unsigned by mode.
// Latency: accept in cycle t -> out_valid first high in cycle t+N+1 (N = WIDTH_U/4).
// Backpressure: single operation in flight; in_ready only in IDLE; product held while out_ready low.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   operand handshake (s, u, mode)
//   s [WIDTH_S-1:0]       signed operand
//   u [WIDTH_U-1:0]       second operand, unsigned (mode=0) or signed (mode=1)
//   out_valid / out_ready result handshake
//   product               signed s*u, WIDTH_S+WIDTH_U bits, zero unless out_valid

module seq_mul_su #(
    parameter int WIDTH_S = 8,
    parameter int WIDTH_U = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_S-1:0]         s,
    input  logic [WIDTH_U-1:0]         u,
    input  logic                       mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_S+WIDTH_U-1:0] product
);

    import seq_mul_su_pkg::*;

    localparam int N  = num_digits(WIDTH_U);
    localparam int AW = WIDTH_S + WIDTH_U;
    localparam int PW = WIDTH_S + 5;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if (!width_ok(WIDTH_S)) begin : g_bad_width_s
        $error("seq_mul_su: WIDTH_S must be a multiple of 4 and at least 4");
    end
    if (!width_ok(WIDTH_U)) begin : g_bad_width_u
        $error("seq_mul_su: WIDTH_U must be a multiple of 4 and at least 4");
    end

    state_e             state_q, state_d;
    logic [WIDTH_S-1:0] s_q, s_d;
    logic [WIDTH_U-1:0] u_q, u_d;
    logic               mode_q, mode_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [KW-1:0]      k_q, k_d;

    logic               last_k;
    logic [3:0]         digit_lo;
    logic [4:0]         digit;
    logic [PW-1:0]      pp;
    logic [AW-1:0]      pp_ext;
    logic [AW-1:0]      pp_shift;

    assign last_k = (k_q == KW'(N - 1));

    // Digit select by constant part-selects keeps every index in range.
    always_comb begin
        digit_lo = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                digit_lo = u_q[4*i +: 4];
            end
        end
    end

    // Only the most significant digit of a signed u carries a sign bit.
    assign digit = {last_k & mode_q & u_q[WIDTH_U-1], digit_lo};

    su_digit_row #(
        .WIDTH_S (WIDTH_S)
    ) u_row (
        .s     (s_q),
        .digit (digit),
        .pp    (pp)
    );

    // Sign-extend (or, for WIDTH_U=4, truncate) the row to accumulator width.
    // Truncation is exact: the final sum always fits WIDTH_S+WIDTH_U bits.
    assign pp_ext   = AW'($signed(pp));
    assign pp_shift = pp_ext << {k_q, 2'b00};

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        u_d       = u_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        k_d       = k_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        product   = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    s_d     = s;
                    u_d     = u;
                    mode_d  = mode;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_q + pp_shift;
                if (last_k) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                product   = acc_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            u_q     <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            u_q     <= u_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: tb/tb_seq_mul_su.sv
// Bench for seq_mul_su: an 8x8 instance (directed + random) and a 4x4 instance (exhaustive).
// Latency: expects first out_valid N+1 cycles after the acceptance edge.
// Backpressure: holds out_ready low for random stretches and checks the result stays put.

module tb_seq_mul_su;

    logic clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready;
    logic [7:0]  a_s, a_u;
    logic [15:0] a_product;

    logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready;
    logic [3:0]  b_s, b_u;
    logic [7:0]  b_product;

    int errors = 0;
    int checks = 0;

    seq_mul_su #(.WIDTH_S(8), .WIDTH_U(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .s(a_s), .u(a_u), .mode(a_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .product(a_product)
    );

    seq_mul_su #(.WIDTH_S(4), .WIDTH_U(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .s(b_s), .u(b_u), .mode(b_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .product(b_product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: interpret the bit patterns as integers and multiply.
    function automatic longint as_signed(input longint v, input int w);
        longint x;
        x = v;
        if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
        return x;
    endfunction

    function automatic longint ref_mul(input longint sv, input longint uv, input logic m,
                                       input int ws, input int wu);
        longint so, uo;
        so = as_signed(sv, ws);
        uo = m ? as_signed(uv, wu) : uv;
        return so * uo;
    endfunction

    task automatic run_a(input logic [7:0] s, input logic [7:0] u, input logic m,
                         input int hold, input string tag);
        longint exp;
        int n;
        exp = ref_mul(longint'(s), longint'(u), m, 8, 8);
        check({tag, "_in_rdy"}, a_in_ready, 1);
        a_s = s; a_u = u; a_mode = m; a_in_valid = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (!a_out_valid && n < 20) begin
            // Operand churn and stray handshakes while busy must be ignored.
            a_s = 8'($urandom); a_u = 8'($urandom); a_mode = 1'($urandom);
            a_in_valid = 1'($urandom); a_out_ready = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        check({tag, "_lat"}, n, 3);
        check({tag, "_prod"}, $signed(a_product), exp);
        check({tag, "_no_in_rdy"}, a_in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_prod"}, $signed(a_product), exp);
            check({tag, "_hold_vld"}, a_out_valid, 1);
            check({tag, "_hold_in_rdy"}, a_in_ready, 0);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check({tag, "_post_vld"}, a_out_valid, 0);
        check({tag, "_post_in_rdy"}, a_in_ready, 1);
    endtask

    task automatic run_b(input logic [3:0] s, input logic [3:0] u, input logic m,
                         input string tag);
        longint exp;
        int n;
        exp = ref_mul(longint'(s), longint'(u), m, 4, 4);
        check({tag, "_in_rdy"}, b_in_ready, 1);
        b_s = s; b_u = u; b_mode = m; b_in_valid = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (!b_out_valid && n < 20) begin
            b_s = 4'($urandom); b_u = 4'($urandom); b_mode = 1'($urandom);
            b_in_valid = 1'($urandom); b_out_ready = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        check({tag, "_lat"}, n, 2);
        check({tag, "_prod"}, $signed(b_product), exp);
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        check({tag, "_post_vld"}, b_out_valid, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        a_in_valid = 0; a_s = 0; a_u = 0; a_mode = 0; a_out_ready = 0;
        b_in_valid = 0; b_s = 0; b_u = 0; b_mode = 0; b_out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_in_rdy", a_in_ready, 1);
        check("rst_a_vld", a_out_valid, 0);
        check("rst_a_prod", a_product, 0);
        check("rst_b_in_rdy", b_in_ready, 1);
        check("rst_b_vld", b_out_valid, 0);
        check("rst_b_prod", b_product, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Boundary and directed cases on the 8x8 instance.
        run_a(8'h80, 8'hFF, 1'b0, 0, "most_neg");
        run_a(8'h80, 8'hFF, 1'b1, 0, "ss_m1");
        run_a(8'h80, 8'h80, 1'b1, 0, "ss_most_pos");
        run_a(8'h7F, 8'hFF, 1'b0, 5, "backpressure");

        // Reset during the first BUSY cycle discards the operation.
        a_s = 8'h05; a_u = 8'h03; a_mode = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy_vld", a_out_valid, 0);
        check("rst_busy_prod", a_product, 0);
        check("rst_busy_in_rdy", a_in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_busy_quiet", a_out_valid, 0);
        end
        run_a(8'hFE, 8'h02, 1'b0, 0, "after_rst");

        // Reset while a product is pending in DONE.
        a_s = 8'h33; a_u = 8'h44; a_mode = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n = 0;
        while (!a_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_done_reach", a_out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_done_vld", a_out_valid, 0);
        check("rst_done_prod", a_product, 0);
        check("rst_done_in_rdy", a_in_ready, 1);

        // Random operands, modes and backpressure lengths.
        repeat (40) begin
            run_a(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rnd");
        end

        // Exhaustive 4x4, both modes.
        for (int m = 0; m < 2; m++) begin
            for (int sv = 0; sv < 16; sv++) begin
                for (int uv = 0; uv < 16; uv++) begin
                    run_b(4'(sv), 4'(uv), 1'(m), "exh");
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
